bcd_seq_subtractor: RTL and testbench



---
 rtl/bcd_seq_subtractor.sv | 192 +++++++++++++++++++
 tb/tb_bcd_seq_subtractor.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seq_subtractor.sv
// bcd_seq_subtractor
//
// Sequential multi-digit BCD subtractor: D = A - B - Bin modulo 10^NDIGITS.
// One decimal digit is resolved per clock, least-significant digit first.
// Operands arrive on a valid/ready handshake and the result leaves on a
// second one.
//
// Parameters:
//   NDIGITS   - number of BCD digits per operand (>= 1)
//
// Ports:
//   clk       - clock, all state changes on the rising edge
//   rst       - synchronous active-high reset
//   in_valid  - A, B and Bin are valid
//   in_ready  - block can accept operands (IDLE only)
//   A, B      - packed BCD minuend / subtrahend, digit i at [4i+3:4i]
//   Bin       - borrow-in
//   out_valid - D, Bout and err are valid (DONE only)
//   out_ready - consumer accepts the result
//   D         - packed BCD difference
//   Bout      - final borrow, 1 when A < B + Bin
//   err       - invalid-digit flag
//
// Build option:
//   BCD_SUB_CHECK_EN - when defined, operands holding any digit > 9 raise
//                      err for that operation and the result is forced to
//                      D = 0, Bout = 0. When undefined, err is tied to 0 and
//                      invalid digits go through the normal arithmetic.

module bcd_seq_subtractor #(
    parameter int NDIGITS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NDIGITS-1:0]   A,
    input  logic [4*NDIGITS-1:0]   B,
    input  logic                   Bin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NDIGITS-1:0]   D,
    output logic                   Bout,
    output logic                   err
);

    localparam int W     = 4 * NDIGITS;
    localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [W-1:0]     a_r;
    logic [W-1:0]     b_r;
    logic [IDX_W-1:0] idx;
    logic             borrow;
    logic [W-1:0]     d_r;
    logic             bout_r;

    logic [3:0]       a_dig;
    logic [3:0]       b_dig;
    logic [3:0]       dig_val;
    logic             dig_borrow;
    logic [3:0]       dig_out;
    logic             bout_nxt;

    // One BCD digit of subtraction. Returns {borrow_out, digit}.
    // The difference is formed as a signed 6-bit value so that the full
    // range -16..15 (including non-BCD inputs) is represented exactly.
    function automatic logic [4:0] sub_digit(input logic [3:0] a,
                                             input logic [3:0] b,
                                             input logic       bi);
        logic signed [5:0] t;
        logic signed [5:0] tw;
        t  = $signed({2'b00, a}) - $signed({2'b00, b}) - $signed({5'b00000, bi});
        tw = t + 6'sd10;
        if (t < 0)
            return {1'b1, tw[3:0]};
        else
            return {1'b0, t[3:0]};
    endfunction

`ifdef BCD_SUB_CHECK_EN
    logic err_r;

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9)
                bad = 1'b1;
        end
        return bad;
    endfunction
`endif

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)        state_nxt = CALC;
            CALC:    if (idx == LAST_IDX) state_nxt = DONE;
            DONE:    if (out_ready)       state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // ---------------- digit datapath ----------------
    always_comb begin
        a_dig = 4'(a_r >> {idx, 2'b00});
        b_dig = 4'(b_r >> {idx, 2'b00});
        {dig_borrow, dig_val} = sub_digit(a_dig, b_dig, borrow);
`ifdef BCD_SUB_CHECK_EN
        // A flagged operation still walks all digits but writes zeros.
        dig_out  = err_r ? 4'd0 : dig_val;
        bout_nxt = err_r ? 1'b0 : dig_borrow;
`else
        dig_out  = dig_val;
        bout_nxt = dig_borrow;
`endif
    end

    // Operand capture: plain data, loaded only on accept.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            a_r <= A;
            b_r <= B;
        end
    end

    // ---------------- control / result registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            borrow <= 1'b0;
            d_r    <= '0;
            bout_r <= 1'b0;
`ifdef BCD_SUB_CHECK_EN
            err_r  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        idx    <= '0;
                        borrow <= Bin;
`ifdef BCD_SUB_CHECK_EN
                        err_r  <= has_bad_digit(A) | has_bad_digit(B);
`endif
                    end
                end
                CALC: begin
                    for (int i = 0; i < NDIGITS; i++) begin
                        if (idx == IDX_W'(i))
                            d_r[4*i +: 4] <= dig_out;
                    end
                    borrow <= dig_borrow;
                    // idx stops at the last digit instead of wrapping.
                    if (idx == LAST_IDX)
                        bout_r <= bout_nxt;
                    else
                        idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign D         = d_r;
    assign Bout      = bout_r;
`ifdef BCD_SUB_CHECK_EN
    assign err       = err_r;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_seq_subtractor.sv
module tb_bcd_seq_subtractor;

    localparam int ND = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   A;
    logic [15:0]   B;
    logic          Bin;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   D;
    logic          Bout;
    logic          err;

    int n_pass  = 0;
    int n_total = 0;

    bcd_seq_subtractor #(.NDIGITS(ND)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .Bout      (Bout),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] d;
        logic        bout;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Independent decimal reference model.
    function automatic int bcd2int(input logic [15:0] v);
        int r;
        r = 0;
        for (int i = ND - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [16:0] ref_sub(input logic [15:0] a, input logic [15:0] b, input logic bi);
        int v;
        logic [15:0] d;
        logic bo;
        v  = bcd2int(a) - bcd2int(b) - int'(bi);
        bo = (v < 0);
        if (v < 0) v += 10000;
        for (int i = 0; i < ND; i++) begin
            d[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return {bo, d};
    endfunction

    // Called at a negedge in IDLE; returns at the negedge of cycle 1.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic bi);
        int n;
        A = a; B = b; Bin = bi; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        // Scramble inputs: captured operands must not follow them.
        A = 16'h5a5a; B = 16'ha5a5; Bin = ~bi;
    endtask

    // lat counts cycles with the accept cycle as 0.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int acc_cyc[3];
        int k_acc;
        int k_res;
        logic [15:0] ops_a[3];
        logic [15:0] ops_b[3];
        logic        ops_bin[3];
        logic [16:0] r;
        bit pending;

        vecs[0] = '{16'h4321, 16'h1234, 1'b0, 16'h3087, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'h9999, 1'b1};
        vecs[2] = '{16'h1000, 16'h0001, 1'b1, 16'h0998, 1'b0};
        vecs[3] = '{16'h9999, 16'h9999, 1'b0, 16'h0000, 1'b0};
        vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'h9999, 1'b1};
        vecs[5] = '{16'h5000, 16'h5000, 1'b1, 16'h9999, 1'b1};
        vecs[6] = '{16'h9999, 16'h0000, 1'b1, 16'h9998, 1'b0};
        vecs[7] = '{16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b0};
        vecs[8] = '{16'h1234, 16'h4321, 1'b0, 16'h6913, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; Bin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_D",         32'(D),         32'd0);
        check("rst_Bout",      32'(Bout),      32'd0);
        check("rst_err",       32'(err),       32'd0);

        // Table-driven vectors
        for (int i = 0; i < 9; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].bin);
            wait_done(lat);
            check($sformatf("vec%0d_latency", i), 32'(lat),  32'd5);
            check($sformatf("vec%0d_D", i),       32'(D),    32'(vecs[i].d));
            check($sformatf("vec%0d_Bout", i),    32'(Bout), 32'(vecs[i].bout));
            check($sformatf("vec%0d_err", i),     32'(err),  32'd0);
            release_result();
            check($sformatf("vec%0d_in_ready_after", i), 32'(in_ready), 32'd1);
        end

        // Backpressure: hold the result for 6 cycles while in_valid pulses
        start_op(16'h4321, 16'h1234, 1'b0);
        wait_done(lat);
        for (int c = 0; c < 6; c++) begin
            check($sformatf("bp%0d_out_valid", c), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d_in_ready", c),  32'(in_ready),  32'd0);
            check($sformatf("bp%0d_D", c),         32'(D),         32'h3087);
            check($sformatf("bp%0d_Bout", c),      32'(Bout),      32'd0);
            in_valid = c[0];
            A = 16'h1111; B = 16'h2222; Bin = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        release_result();
        check("bp_release_in_ready",  32'(in_ready),  32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        check("bp_release_D_kept",    32'(D),         32'h3087);

        // Reset mid-CALC: rst high during cycle 2
        start_op(16'h9999, 16'h0001, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_D",         32'(D),         32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        check("midrst_Bout",      32'(Bout),      32'd0);
        start_op(16'h0005, 16'h0005, 1'b0);
        wait_done(lat);
        check("postrst_latency", 32'(lat),  32'd5);
        check("postrst_D",       32'(D),    32'h0000);
        check("postrst_Bout",    32'(Bout), 32'd0);
        release_result();

        // Invalid digit
        start_op(16'h00A0, 16'h0001, 1'b0);
        wait_done(lat);
        check("inv_latency", 32'(lat), 32'd5);
`ifdef BCD_SUB_CHECK_EN
        check("inv_err",  32'(err),  32'd1);
        check("inv_D",    32'(D),    32'h0000);
        check("inv_Bout", 32'(Bout), 32'd0);
`else
        // Digit 1 is 10: 0-1 -> 9 borrow, 10-0-1 -> 9, upper digits 0.
        check("inv_err",  32'(err),  32'd0);
        check("inv_D",    32'(D),    32'h0099);
        check("inv_Bout", 32'(Bout), 32'd0);
`endif
        release_result();
        start_op(16'h0050, 16'h0001, 1'b0);
        wait_done(lat);
        check("inv_next_err",  32'(err),  32'd0);
        check("inv_next_D",    32'(D),    32'h0049);
        check("inv_next_Bout", 32'(Bout), 32'd0);
        release_result();

        // Back-to-back: in_valid held high, out_ready held high
        ops_a[0] = 16'h2468; ops_b[0] = 16'h1357; ops_bin[0] = 1'b1;
        ops_a[1] = 16'h0100; ops_b[1] = 16'h0200; ops_bin[1] = 1'b0;
        ops_a[2] = 16'h7531; ops_b[2] = 16'h0999; ops_bin[2] = 1'b1;
        k_acc = 0; k_res = 0;
        A = ops_a[0]; B = ops_b[0]; Bin = ops_bin[0];
        in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            pending = 1'b0;
            if (out_valid && k_res < 3) begin
                r = ref_sub(ops_a[k_res], ops_b[k_res], ops_bin[k_res]);
                check($sformatf("b2b%0d_D", k_res),    32'(D),    32'(r[15:0]));
                check($sformatf("b2b%0d_Bout", k_res), 32'(Bout), 32'(r[16]));
                k_res++;
            end
            if (in_valid && in_ready && k_acc < 3) begin
                acc_cyc[k_acc] = cyc;
                k_acc++;
                pending = 1'b1;
            end
            @(posedge clk);
            #1;
            if (pending) begin
                if (k_acc < 3) begin
                    A = ops_a[k_acc]; B = ops_b[k_acc]; Bin = ops_bin[k_acc];
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("b2b_accepts", 32'(k_acc), 32'd3);
        check("b2b_results", 32'(k_res), 32'd3);
        if (k_acc == 3) begin
            check("b2b_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
            check("b2b_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd6);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
